// File: rtl/fft32_stage_feeder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft32_stage_feeder_if : sample-in / operand-pair-out bus of the FFT32 feeder
// Rev 1.0
// -----------------------------------------------------------------------------
interface fft32_stage_feeder_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_r;
  logic [N-1:0] in_i;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out0_r;
  logic [N-1:0] out0_i;
  logic [N-1:0] out1_r;
  logic [N-1:0] out1_i;
  logic [3:0]   tw_idx;
  logic         frame_done;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out0_r, out0_i, out1_r, out1_i, tw_idx, frame_done
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out0_r, out0_i, out1_r, out1_i, tw_idx, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fft32_stage_feeder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft32_stage_feeder : buffers 32 samples, then issues 16 radix-2 operand pairs
// Optional macro FEEDER_SCALE_EN: halve each sample (arithmetic shift) on write.
// Rev 1.0
// -----------------------------------------------------------------------------
module fft32_stage_feeder #(
  parameter int N      = 16,
  parameter int STAGE  = 0,
  parameter int BITREV = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fft32_stage_feeder_if.slave bus
);

  localparam int SPAN = 1 << STAGE;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [2*N-1:0] r_mem [32];
  logic [4:0]     r_load_cnt;
  logic [3:0]     r_pair_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_frame_done;
  logic [N-1:0]   r_out0_r;
  logic [N-1:0]   r_out0_i;
  logic [N-1:0]   r_out1_r;
  logic [N-1:0]   r_out1_i;
  logic [3:0]     r_tw_idx;

  logic           w_wr_en;
  logic           w_ld_out;
  logic           w_fin;
  logic           w_xfer;
  logic [4:0]     w_rev_addr;
  logic [4:0]     w_wr_addr;
  logic [N-1:0]   w_wr_r;
  logic [N-1:0]   w_wr_i;
  logic [3:0]     w_rd_pair;
  logic [4:0]     w_rd_pair5;
  logic [4:0]     w_grp;
  logic [4:0]     w_ofs;
  logic [4:0]     w_idx0;
  logic [4:0]     w_idx1;
  logic [3:0]     w_tw;

  for (genvar b = 0; b < 5; b++) begin : g_bitrev
    assign w_rev_addr[b] = r_load_cnt[4-b];
  end

  assign w_wr_addr = (BITREV != 0) ? w_rev_addr : r_load_cnt;

`ifdef FEEDER_SCALE_EN
  assign w_wr_r = {bus.in_r[N-1], bus.in_r[N-1:1]};
  assign w_wr_i = {bus.in_i[N-1], bus.in_i[N-1:1]};
`else
  assign w_wr_r = bus.in_r;
  assign w_wr_i = bus.in_i;
`endif

  // While a pair is on the bus, the pair being fetched is the following one.
  assign w_rd_pair  = r_out_valid ? (r_pair_cnt + 4'd1) : r_pair_cnt;
  assign w_rd_pair5 = {1'b0, w_rd_pair};
  assign w_grp      = w_rd_pair5 >> STAGE;
  assign w_ofs      = w_rd_pair5 & 5'(SPAN - 1);
  assign w_idx0     = (w_grp << (STAGE + 1)) | w_ofs;
  assign w_idx1     = w_idx0 | 5'(SPAN);
  assign w_tw       = 4'(w_ofs << (4 - STAGE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_ld_out    = 1'b0;
    w_fin       = 1'b0;
    w_xfer      = r_out_valid & bus.out_ready;
    case (r_state)
      LOAD: begin
        w_wr_en = bus.in_valid & r_in_ready;
        if (w_wr_en && (r_load_cnt == 5'd31)) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!r_out_valid) begin
          w_ld_out = 1'b1;
        end else if (w_xfer) begin
          if (r_pair_cnt == 4'd15) begin
            w_fin       = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_ld_out = 1'b1;
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Sample storage carries no reset; a new frame overwrites every entry.
  always_ff @(posedge clk) begin
    if (w_wr_en && rst) begin
      r_mem[w_wr_addr] <= {w_wr_r, w_wr_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_load_cnt   <= 5'd0;
      r_pair_cnt   <= 4'd0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out0_r     <= '0;
      r_out0_i     <= '0;
      r_out1_r     <= '0;
      r_out1_i     <= '0;
      r_tw_idx     <= 4'd0;
    end else begin
      r_in_ready   <= (w_state_nxt == LOAD);
      r_frame_done <= w_fin;
      if (w_wr_en) begin
        r_load_cnt <= r_load_cnt + 5'd1;
      end
      if (w_ld_out) begin
        r_out0_r    <= r_mem[w_idx0][2*N-1:N];
        r_out0_i    <= r_mem[w_idx0][N-1:0];
        r_out1_r    <= r_mem[w_idx1][2*N-1:N];
        r_out1_i    <= r_mem[w_idx1][N-1:0];
        r_tw_idx    <= w_tw;
        r_out_valid <= 1'b1;
        r_pair_cnt  <= w_rd_pair;
      end else if (w_fin) begin
        r_out_valid <= 1'b0;
        r_pair_cnt  <= 4'd0;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out0_r     = r_out0_r;
  assign bus.out0_i     = r_out0_i;
  assign bus.out1_r     = r_out1_r;
  assign bus.out1_i     = r_out1_i;
  assign bus.tw_idx     = r_tw_idx;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fft32_stage_feeder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fft32_stage_feeder : scoreboard bench, two feeder configurations
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_fft32_stage_feeder;

  typedef struct packed {
    logic [15:0] o0r;
    logic [15:0] o0i;
    logic [15:0] o1r;
    logic [15:0] o1i;
    logic [3:0]  tw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_valid_s;
  logic        out_ready_s;
  logic        stall_en;
  logic [15:0] in_r_s;
  logic [15:0] in_i_s;

  always #5 clk = ~clk;

  fft32_stage_feeder_if #(.N(16)) ifa ();
  fft32_stage_feeder_if #(.N(16)) ifb ();

  assign ifa.in_valid  = in_valid_s & ~sel;
  assign ifa.in_r      = in_r_s;
  assign ifa.in_i      = in_i_s;
  assign ifa.out_ready = out_ready_s & ~sel;
  assign ifb.in_valid  = in_valid_s & sel;
  assign ifb.in_r      = in_r_s;
  assign ifb.in_i      = in_i_s;
  assign ifb.out_ready = out_ready_s & sel;

  fft32_stage_feeder #(.N(16), .STAGE(0), .BITREV(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fft32_stage_feeder #(.N(16), .STAGE(2), .BITREV(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic        m_in_ready, m_out_valid, m_frame_done;
  logic [15:0] m_o0r, m_o0i, m_o1r, m_o1i;
  logic [3:0]  m_tw;
  assign m_in_ready   = sel ? ifb.in_ready   : ifa.in_ready;
  assign m_out_valid  = sel ? ifb.out_valid  : ifa.out_valid;
  assign m_frame_done = sel ? ifb.frame_done : ifa.frame_done;
  assign m_o0r        = sel ? ifb.out0_r     : ifa.out0_r;
  assign m_o0i        = sel ? ifb.out0_i     : ifa.out0_i;
  assign m_o1r        = sel ? ifb.out1_r     : ifa.out1_r;
  assign m_o1i        = sel ? ifb.out1_i     : ifa.out1_i;
  assign m_tw         = sel ? ifb.tw_idx     : ifa.tw_idx;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  int          fd_count = 0;
  int          vcnt = 0;
  int          stall_cnt = 0;
  exp_t        q[$];
  logic [15:0] cap_o0r [16];
  logic [15:0] cap_o1r [16];
  logic [3:0]  cap_tw  [16];
  logic [15:0] fr [32];
  logic [15:0] fi [32];
  logic        hold_prev = 1'b0;
  exp_t        prev_v;

  function automatic logic [15:0] h(input logic [15:0] x);
`ifdef FEEDER_SCALE_EN
    return {x[15], x[15:1]};
`else
    return x;
`endif
  endfunction

  function automatic int bitrev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) r |= ((k >> b) & 1) << (4 - b);
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input int br, input int stage);
    logic [15:0] mr [32];
    logic [15:0] mi [32];
    exp_t        e;
    int          span, i0, i1, a;
    for (int k = 0; k < 32; k++) begin
      a     = (br != 0) ? bitrev5(k) : k;
      mr[a] = h(fr[k]);
      mi[a] = h(fi[k]);
    end
    span = 1 << stage;
    for (int p = 0; p < 16; p++) begin
      i0    = (p / span) * 2 * span + (p % span);
      i1    = i0 + span;
      e.o0r = mr[i0];
      e.o0i = mi[i0];
      e.o1r = mr[i1];
      e.o1i = mi[i1];
      e.tw  = 4'((p % span) * (16 / span));
      q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int k);
    int t = 0;
    in_valid_s = 1'b1;
    in_r_s     = fr[k];
    in_i_s     = fi[k];
    while (!m_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!m_in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: sample %0d never accepted", k);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (fd_count < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (fd_count < target) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: frame_done count %0d want %0d", fd_count, target);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (stall_en && ((pops % 16) == 3) && stall_cnt < 4) begin
      out_ready_s = 1'b0;
      stall_cnt++;
    end else begin
      out_ready_s = 1'b1;
      if ((pops % 16) != 3) stall_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = {m_o0r, m_o0i, m_o1r, m_o1i, m_tw};
    if (rst) begin
      if (m_out_valid) vcnt++;
      if (hold_prev && m_out_valid) begin
        total++;
        if (cur !== prev_v) begin
          bad++;
          $display("FAIL hold_stable: got %h want %h", cur, prev_v);
        end
      end
      if (m_out_valid && out_ready_s) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pair: got %h with nothing expected", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL pair_data p=%0d: got %h want %h", pops % 16, cur, e);
          end
        end
        cap_o0r[pops % 16] = m_o0r;
        cap_o1r[pops % 16] = m_o1r;
        cap_tw[pops % 16]  = m_tw;
        pops++;
      end
      if (m_frame_done) begin
        fd_count++;
        total++;
        if (!(m_in_ready === 1'b1 && m_out_valid === 1'b0 && q.size() == 0)) begin
          bad++;
          $display("FAIL frame_done_state: in_ready=%b out_valid=%b pending=%0d want 1 0 0",
                   m_in_ready, m_out_valid, q.size());
        end
      end
      hold_prev = m_out_valid && !out_ready_s;
      prev_v    = cur;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int vstart, fstart, seen;
    rst        = 1'b0;
    sel        = 1'b0;
    stall_en   = 1'b0;
    in_valid_s = 1'b1;
    in_r_s     = 16'h1234;
    in_i_s     = 16'h5678;
    repeat (3) begin
      @(negedge clk);
      chk("reset_in_ready", 80'(m_in_ready), 80'd0);
      chk("reset_outputs", 80'({m_out_valid, m_frame_done, m_o0r, m_o0i, m_o1r, m_o1i, m_tw}), 80'd0);
    end
    rst        = 1'b1;
    in_valid_s = 1'b0;

    // Frame A1: STAGE 0, bit-reversed load
    for (int k = 0; k < 32; k++) begin
      fr[k] = 16'(k);
      fi[k] = 16'(-k);
    end
    for (int k = 0; k < 32; k++) send(k);
    push_frame(1, 0);
    in_valid_s = 1'b1;
    in_r_s     = 16'hDEAD;
    in_i_s     = 16'hBEEF;
    chk("issue_in_ready", 80'(m_in_ready), 80'd0);
    vstart = vcnt;
    fstart = fd_count;
    wait_done(fstart + 1);
    in_valid_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_valid_cycles", 80'(vcnt - vstart), 80'd16);
    chk("a_frame_done_once", 80'(fd_count - fstart), 80'd1);
    chk("a_p0_out0_r", 80'(cap_o0r[0]), 80'(h(16'd0)));
    chk("a_p0_out1_r", 80'(cap_o1r[0]), 80'(h(16'd16)));
    chk("a_p0_tw", 80'(cap_tw[0]), 80'd0);
    chk("a_p1_out0_r", 80'(cap_o0r[1]), 80'(h(16'd8)));
    chk("a_p1_out1_r", 80'(cap_o1r[1]), 80'(h(16'd24)));

    // Mid-frame reset on A: the partial frame is discarded
    for (int k = 0; k < 32; k++) begin
      fr[k] = 16'(k + 100);
      fi[k] = 16'(k + 200);
    end
    for (int k = 0; k < 20; k++) send(k);
    in_valid_s = 1'b0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 31; k++) send(k);
    in_valid_s = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_out_valid) seen = 1;
    end
    chk("midreset_no_issue", 80'(seen), 80'd0);
    send(31);
    in_valid_s = 1'b0;
    push_frame(1, 0);
    fstart = fd_count;
    wait_done(fstart + 1);
    repeat (2) @(negedge clk);
    chk("mr_p0_out0_r", 80'(cap_o0r[0]), 80'(h(16'd100)));
    chk("mr_p0_out1_r", 80'(cap_o1r[0]), 80'(h(16'd116)));

    // Frame B1: STAGE 2, natural order, backpressure on pair 3
    sel = 1'b1;
    for (int k = 0; k < 32; k++) begin
      fr[k] = 16'(k);
      fi[k] = 16'(32 - k);
    end
    stall_en = 1'b1;
    for (int k = 0; k < 32; k++) send(k);
    in_valid_s = 1'b0;
    push_frame(0, 2);
    vstart = vcnt;
    fstart = fd_count;
    wait_done(fstart + 1);
    stall_en = 1'b0;
    chk("b_p5_out0_r", 80'(cap_o0r[5]), 80'(h(16'd9)));
    chk("b_p5_out1_r", 80'(cap_o1r[5]), 80'(h(16'd13)));
    chk("b_p5_tw", 80'(cap_tw[5]), 80'd4);
    chk("b_p15_out0_r", 80'(cap_o0r[15]), 80'(h(16'd27)));
    chk("b_p15_out1_r", 80'(cap_o1r[15]), 80'(h(16'd31)));
    chk("b_p15_tw", 80'(cap_tw[15]), 80'd12);

    // Frame B2 starts straight after frame_done; checks the write path scaling
    for (int k = 0; k < 32; k++) begin
      fr[k] = 16'(k);
      fi[k] = 16'(k);
    end
    fr[0] = 16'h8003;
    for (int k = 0; k < 32; k++) send(k);
    in_valid_s = 1'b0;
    chk("b_valid_cycles", 80'(vcnt - vstart), 80'd20);
    chk("b_frame_done_once", 80'(fd_count - fstart), 80'd1);
    push_frame(0, 2);
    fstart = fd_count;
    wait_done(fstart + 1);
    repeat (2) @(negedge clk);
`ifdef FEEDER_SCALE_EN
    chk("scale_out0_r", 80'(cap_o0r[0]), 80'h0000_0000_0000_0000_C001);
`else
    chk("scale_out0_r", 80'(cap_o0r[0]), 80'h0000_0000_0000_0000_8003);
`endif
    chk("queue_drained", 80'(q.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
